// File: rtl/seq_ctl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_ctl_if
// Purpose  : Control and status bundle of the seq_ctl sequence controller.
//            master = the side that drives the controls (control logic),
//            slave  = seq_ctl itself.
// Signals  : run, hlt_req, clr_sc, ien_set, ien_clr, fgi, fgo  (to slave)
//            t[15:0], r_cycle, ien, halted, state[1:0], sc_ovf (from slave)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface seq_ctl_if;
  logic        run;
  logic        hlt_req;
  logic        clr_sc;
  logic        ien_set;
  logic        ien_clr;
  logic        fgi;
  logic        fgo;
  logic [15:0] t;
  logic        r_cycle;
  logic        ien;
  logic        halted;
  logic [1:0]  state;
  logic        sc_ovf;

  modport master (
    output run, hlt_req, clr_sc, ien_set, ien_clr, fgi, fgo,
    input  t, r_cycle, ien, halted, state, sc_ovf
  );

  modport slave (
    input  run, hlt_req, clr_sc, ien_set, ien_clr, fgi, fgo,
    output t, r_cycle, ien, halted, state, sc_ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_ctl
// Purpose  : Sequence controller: IDLE/RUN/HALT FSM, 4-bit sequence counter
//            with one-hot timing outputs T0..T15, sticky counter-wrap flag,
//            and an optional interrupt cycle (R flag / IEN flag).
// Ports    : myclock  - single clock, rising edge
//            reset    - synchronous active-high reset
//            bus      - seq_ctl_if.slave (controls in, t/r_cycle/ien/halted/
//                       state/sc_ovf out)
// Config   : define INT_CYCLE_EN to compile in the interrupt-cycle logic;
//            without it r_cycle and ien are constant 0 and ien_set, ien_clr,
//            fgi, fgo are ignored.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module seq_ctl (
  input  wire logic myclock,
  input  wire logic reset,
  seq_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic        r_q, r_d;
  logic        ien_q, ien_d;
  logic        ovf_q, ovf_d;
  logic [15:0] t_q, t_d;
  logic        halted_q, halted_d;
  logic        int_exit;
  logic        t3;

  assign t3 = (sc_q == 4'd3);

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    r_d      = r_q;
    ien_d    = ien_q;
    ovf_d    = ovf_q;
    int_exit = 1'b0;
`ifdef INT_CYCLE_EN
    // Last step of the interrupt cycle (R & T2).
    int_exit = r_q && (sc_q == 4'd2);
`endif
    // run=0 leaves every *_d equal to its *_q, freezing the whole block.
    if (bus.run) begin
      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN: begin
          // Halting keeps sc at 3; halt beats clr_sc.
          if (bus.hlt_req && t3) begin
            state_d = S_HALT;
          end else if (int_exit || bus.clr_sc) begin
            sc_d = 4'd0;
          end else begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd15) ovf_d = 1'b1;
          end
`ifdef INT_CYCLE_EN
          if (int_exit) begin
            // Exit clear overrides any ien_set this cycle.
            r_d   = 1'b0;
            ien_d = 1'b0;
          end else begin
            // Interrupt is only taken outside T0..T2.
            if (!r_q && ien_q && (bus.fgi || bus.fgo) && (sc_q >= 4'd3))
              r_d = 1'b1;
            if (bus.ien_clr)      ien_d = 1'b0;
            else if (bus.ien_set) ien_d = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
    // Outputs are precomputed from the next state so they come straight from flops.
    t_d      = (state_d == S_RUN) ? (16'd1 << sc_d) : 16'd0;
    halted_d = (state_d == S_HALT);
  end

`ifndef INT_CYCLE_EN
  logic unused_int_inputs;
  assign unused_int_inputs = ^{bus.ien_set, bus.ien_clr, bus.fgi, bus.fgo};
`endif

  always_ff @(posedge myclock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sc_q     <= 4'd0;
      r_q      <= 1'b0;
      ien_q    <= 1'b0;
      ovf_q    <= 1'b0;
      t_q      <= 16'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      r_q      <= r_d;
      ien_q    <= ien_d;
      ovf_q    <= ovf_d;
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign bus.t       = t_q;
  assign bus.r_cycle = r_q;
  assign bus.ien     = ien_q;
  assign bus.halted  = halted_q;
  assign bus.state   = state_q;
  assign bus.sc_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_seq_ctl
// Purpose  : Self-checking bench for seq_ctl: reset checks, a vector table,
//            directed multi-cycle sequences and a random run against a
//            behavioural model. Honours INT_CYCLE_EN like the design.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_seq_ctl;

`ifdef INT_CYCLE_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic myclock = 1'b0;
  logic reset   = 1'b1;

  seq_ctl_if bus ();

  seq_ctl dut (
    .myclock (myclock),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 myclock = ~myclock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: state 0 idle / 1 run / 2 halt, sc as plain integer.
  int m_state = 0;
  int m_sc    = 0;
  bit m_r     = 1'b0;
  bit m_ien   = 1'b0;
  bit m_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, rn, hl, cl, es, ec, fi, fo);
    int  old_sc;
    bit  old_r;
    bit  old_ien;
    bit  leaving;
    if (rs) begin
      m_state = 0; m_sc = 0; m_r = 0; m_ien = 0; m_ovf = 0;
    end else if (rn) begin
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        old_sc  = m_sc;
        old_r   = m_r;
        old_ien = m_ien;
        leaving = INT_EN && old_r && (old_sc == 2);
        if (hl && old_sc == 3) m_state = 2;
        else if (leaving || cl) m_sc = 0;
        else begin
          m_sc = (old_sc + 1) % 16;
          if (old_sc == 15) m_ovf = 1;
        end
        if (INT_EN) begin
          if (leaving) begin
            m_r = 0; m_ien = 0;
          end else begin
            if (!old_r && old_ien && (fi || fo) && old_sc > 2) m_r = 1;
            if (ec) m_ien = 0;
            else if (es) m_ien = 1;
          end
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic drive(input bit rs, rn, hl, cl, es, ec, fi, fo);
    reset       = rs;
    bus.run     = rn;
    bus.hlt_req = hl;
    bus.clr_sc  = cl;
    bus.ien_set = es;
    bus.ien_clr = ec;
    bus.fgi     = fi;
    bus.fgo     = fo;
    @(posedge myclock);
    #1;
    model_step(rs, rn, hl, cl, es, ec, fi, fo);
  endtask

  task automatic run1(input bit cl);
    drive(0, 1, 0, cl, 0, 0, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".t"},      32'(bus.t),       32'h0);
    check({tag, ".state"},  32'(bus.state),   32'h0);
    check({tag, ".halted"}, 32'(bus.halted),  32'h0);
    check({tag, ".sc_ovf"}, 32'(bus.sc_ovf),  32'h0);
    check({tag, ".r"},      32'(bus.r_cycle), 32'h0);
    check({tag, ".ien"},    32'(bus.ien),     32'h0);
  endtask

  task automatic check_model(input int cyc);
    logic [15:0] et;
    et = (m_state == 1) ? (16'd1 << m_sc) : 16'd0;
    n_cmp++;
    if (bus.t !== et || bus.state !== 2'(m_state) || bus.halted !== (m_state == 2) ||
        bus.sc_ovf !== m_ovf || bus.r_cycle !== m_r || bus.ien !== m_ien) begin
      n_bad++;
      $display("FAIL rand[%0d]: got t=%h st=%0d h=%0b ovf=%0b r=%0b ien=%0b expected t=%h st=%0d h=%0b ovf=%0b r=%0b ien=%0b",
               cyc, bus.t, bus.state, bus.halted, bus.sc_ovf, bus.r_cycle, bus.ien,
               et, m_state, (m_state == 2), m_ovf, m_r, m_ien);
    end
  endtask

  typedef struct {
    bit          run;
    bit          hlt;
    bit          clr;
    logic [15:0] exp_t;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // run, hlt, clr -> expected t and state after the edge
    vecs[0]  = '{1, 0, 0, 16'h0001, 2'd1};  // IDLE -> RUN at T0
    vecs[1]  = '{1, 0, 0, 16'h0002, 2'd1};
    vecs[2]  = '{1, 0, 0, 16'h0004, 2'd1};
    vecs[3]  = '{0, 0, 0, 16'h0004, 2'd1};  // run low 5 cycles at T2
    vecs[4]  = '{0, 0, 0, 16'h0004, 2'd1};
    vecs[5]  = '{0, 0, 0, 16'h0004, 2'd1};
    vecs[6]  = '{0, 0, 0, 16'h0004, 2'd1};
    vecs[7]  = '{0, 0, 0, 16'h0004, 2'd1};
    vecs[8]  = '{1, 0, 0, 16'h0008, 2'd1};  // resume -> T3
    vecs[9]  = '{1, 0, 0, 16'h0010, 2'd1};
    vecs[10] = '{1, 0, 1, 16'h0001, 2'd1};  // clr_sc at T4
    vecs[11] = '{1, 1, 0, 16'h0002, 2'd1};  // hlt at T0 ignored
    vecs[12] = '{1, 1, 0, 16'h0004, 2'd1};  // hlt at T1 ignored
    vecs[13] = '{1, 0, 0, 16'h0008, 2'd1};
    vecs[14] = '{1, 1, 1, 16'h0000, 2'd2};  // hlt+clr at T3: halt wins
    vecs[15] = '{1, 1, 0, 16'h0000, 2'd2};
    vecs[16] = '{0, 0, 1, 16'h0000, 2'd2};

    // Reset state
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_reset_vals("reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_hold.state", 32'(bus.state), 32'h0);
    check("idle_hold.t",     32'(bus.t),     32'h0);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      drive(0, vecs[i].run, vecs[i].hlt, vecs[i].clr, 0, 0, 0, 0);
      check($sformatf("vec%0d.t", i),      32'(bus.t),      32'(vecs[i].exp_t));
      check($sformatf("vec%0d.state", i),  32'(bus.state),  32'(vecs[i].exp_st));
      check($sformatf("vec%0d.halted", i), 32'(bus.halted), 32'(vecs[i].exp_st == 2'd2));
    end

    // Reset out of HALT
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    check_reset_vals("reset_halt");

    // Counter wrap sets sticky sc_ovf
    run1(0);
    for (int i = 1; i < 16; i++) run1(0);
    check("wrap.t15",     32'(bus.t),      32'h8000);
    check("wrap.ovf_pre", 32'(bus.sc_ovf), 32'h0);
    run1(0);
    check("wrap.t0",      32'(bus.t),      32'h0001);
    check("wrap.ovf",     32'(bus.sc_ovf), 32'h1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap.ovf_hold", 32'(bus.sc_ovf), 32'h1);
    check("wrap.t_hold",   32'(bus.t),      32'h0001);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap.ovf_reset", 32'(bus.sc_ovf), 32'h0);

`ifdef INT_CYCLE_EN
    // Interrupt cycle
    run1(0);                              // T0
    drive(0, 1, 0, 0, 1, 0, 0, 0);        // ION at T0 -> T1
    check("int.ien_set", 32'(bus.ien), 32'h1);
    drive(0, 1, 0, 0, 1, 1, 0, 0);        // ION+IOF -> clear wins
    check("int.ien_both", 32'(bus.ien), 32'h0);
    drive(0, 1, 0, 0, 1, 0, 0, 0);        // -> T3, IEN=1
    run1(0);                              // -> T4
    run1(0);                              // -> T5
    check("int.no_r", 32'(bus.r_cycle), 32'h0);
    drive(0, 1, 0, 1, 0, 0, 1, 0);        // fgi + clr at T5
    check("int.r_t0.t", 32'(bus.t),       32'h0001);
    check("int.r_t0.r", 32'(bus.r_cycle), 32'h1);
    run1(0);
    check("int.r_t1", 32'({bus.r_cycle, bus.t}), 32'h10002);
    run1(0);
    check("int.r_t2", 32'({bus.r_cycle, bus.t}), 32'h10004);
    drive(0, 1, 0, 0, 1, 0, 0, 0);        // ION at R&T2 is overridden
    check("int.exit.t",   32'(bus.t),       32'h0001);
    check("int.exit.r",   32'(bus.r_cycle), 32'h0);
    check("int.exit.ien", 32'(bus.ien),     32'h0);
    // Reset during T6 of an interrupt-started sequence
    drive(0, 1, 0, 0, 1, 0, 0, 0);        // -> T1, IEN=1
    drive(0, 1, 0, 0, 0, 0, 0, 1);        // fgo at T1 -> no R
    drive(0, 1, 0, 0, 0, 0, 0, 1);        // fgo at T2 -> no R, T3
    check("int.t2_block", 32'(bus.r_cycle), 32'h0);
    drive(0, 1, 0, 0, 0, 0, 0, 1);        // fgo at T3 -> R=1, T4
    check("int.r_at_t3", 32'({bus.r_cycle, bus.t}), 32'h10010);
    run1(0);
    run1(0);                              // T6
    drive(1, 1, 1, 1, 1, 0, 1, 1);
    check_reset_vals("reset_int");
`else
    // Interrupt inputs have no effect
    run1(0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 1, 0, 1, 1);
    check("noint.t",   32'(bus.t),       32'h0040);
    check("noint.r",   32'(bus.r_cycle), 32'h0);
    check("noint.ien", 32'(bus.ien),     32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Random stimulus against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 29) == 0,  $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0,   $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0,   $urandom_range(0, 7) == 0);
      check_model(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
